// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweeper.
//   tt_state_t : sweep controller states (IDLE -> RUN -> DONE -> IDLE)
//   TT_G01D    : 3-input exercise function table (f = 1 for vectors 1, 3, 7)
//   TT_ZERO    : 3-input constant-0 table
//   TT_ONE     : 3-input constant-1 table
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tt_state_t;

   localparam logic [7:0] TT_G01D = 8'h8A;
   localparam logic [7:0] TT_ZERO = 8'h00;
   localparam logic [7:0] TT_ONE  = 8'hFF;

endpackage

// File: rtl/tt_lookup.sv
// Combinational table lookup for the sweeper.
// Ports:
//   tt_l      in  TW : latched function table
//   exp_l     in  TW : latched expected table
//   idx       in  N  : input vector being evaluated
//   s_next    out 1  : f(idx)
//   mism_next out 1  : f(idx) differs from expected(idx)
module tt_lookup #(
   parameter int N  = 3,
   parameter int TW = 2**N
) (
   input  logic [TW-1:0] tt_l,
   input  logic [TW-1:0] exp_l,
   input  logic [N-1:0]  idx,
   output logic          s_next,
   output logic          mism_next
);

   assign s_next    = tt_l[idx];
   assign mism_next = tt_l[idx] ^ exp_l[idx];

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked truth-table sweeper: latches an N-input function table and an
// expected table on start, then presents every input vector 0..2^N-1 in
// order (one per unstalled clock) with its function output and a mismatch
// flag, accumulating minterm and mismatch statistics.
// Ports:
//   clk, reset       : clock (rising edge), async active-high reset
//   start            : begin a sweep (accepted in IDLE only)
//   hold             : stall the sweep while high (RUN only)
//   tt, exp_tt       : function / expected truth tables, bit i = f(vector i)
//   busy             : sweep in progress
//   valid            : vec/s/mism meaningful this cycle
//   vec, s, mism     : current vector, f(vec), f(vec) != expected(vec)
//   done             : one-cycle pulse after the final vector
//   ones_count       : number of vectors with f = 1
//   err_count        : number of mismatching vectors
//   first_bad        : lowest mismatching vector (0 if none)
//   any_bad          : at least one mismatch seen
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int N  = 3,
   parameter int TW = 2**N
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          hold,
   input  logic [TW-1:0] tt,
   input  logic [TW-1:0] exp_tt,
   output logic          busy,
   output logic          valid,
   output logic [N-1:0]  vec,
   output logic          s,
   output logic          mism,
   output logic          done,
   output logic [N:0]    ones_count,
   output logic [N:0]    err_count,
   output logic [N-1:0]  first_bad,
   output logic          any_bad
);

   // Counter is one bit wider than the vector so the terminal compare
   // against TW-1 stays exact even for N=8.
   localparam logic [N:0] LAST = (N+1)'(TW - 1);

   tt_state_t     state;
   logic [N:0]    cnt;
   logic [TW-1:0] tt_l;
   logic [TW-1:0] exp_l;
   logic          s_next;
   logic          mism_next;

   tt_lookup #(.N(N), .TW(TW)) u_lookup (
      .tt_l      (tt_l),
      .exp_l     (exp_l),
      .idx       (cnt[N-1:0]),
      .s_next    (s_next),
      .mism_next (mism_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         tt_l       <= '0;
         exp_l      <= '0;
         busy       <= 1'b0;
         valid      <= 1'b0;
         vec        <= '0;
         s          <= 1'b0;
         mism       <= 1'b0;
         done       <= 1'b0;
         ones_count <= '0;
         err_count  <= '0;
         first_bad  <= '0;
         any_bad    <= 1'b0;
      end else begin
         valid <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  tt_l       <= tt;
                  exp_l      <= exp_tt;
                  ones_count <= '0;
                  err_count  <= '0;
                  first_bad  <= '0;
                  any_bad    <= 1'b0;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               // On hold, valid drops (default above) and everything else
               // keeps its value, so vec/s show the last presented vector.
               if (!hold) begin
                  vec        <= cnt[N-1:0];
                  s          <= s_next;
                  mism       <= mism_next;
                  valid      <= 1'b1;
                  ones_count <= ones_count + (N+1)'(s_next);
                  err_count  <= err_count + (N+1)'(mism_next);
                  if (mism_next && !any_bad) begin
                     first_bad <= cnt[N-1:0];
                     any_bad   <= 1'b1;
                  end
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     busy  <= 1'b0;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper (N=3 and N=8 instances).
module tb_truth_table_sweeper;
   import tt_pkg::*;

   typedef struct {
      int vec;
      bit s;
      bit mism;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // N=3 instance
   logic       start3, hold3;
   logic [7:0] tt3, exp3;
   logic       busy3, valid3, s3, mism3, done3, any_bad3;
   logic [2:0] vec3, first_bad3;
   logic [3:0] ones3, err3;

   // N=8 instance
   logic         start8, hold8;
   logic [255:0] tt8, exp8;
   logic         busy8, valid8, s8, mism8, done8, any_bad8;
   logic [7:0]   vec8, first_bad8;
   logic [8:0]   ones8, err8;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t sb3[$];
   exp_t sb8[$];

   truth_table_sweeper #(.N(3)) dut3 (
      .clk(clk), .reset(rst), .start(start3), .hold(hold3),
      .tt(tt3), .exp_tt(exp3),
      .busy(busy3), .valid(valid3), .vec(vec3), .s(s3), .mism(mism3),
      .done(done3), .ones_count(ones3), .err_count(err3),
      .first_bad(first_bad3), .any_bad(any_bad3)
   );

   truth_table_sweeper #(.N(8)) dut8 (
      .clk(clk), .reset(rst), .start(start8), .hold(hold8),
      .tt(tt8), .exp_tt(exp8),
      .busy(busy8), .valid(valid8), .vec(vec8), .s(s8), .mism(mism8),
      .done(done8), .ones_count(ones8), .err_count(err8),
      .first_bad(first_bad8), .any_bad(any_bad8)
   );

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Output monitors: every valid beat is matched against the scoreboard.
   exp_t m3, m8;
   always @(negedge clk) begin
      if (!rst && valid3) begin
         if (sb3.size() == 0) check_eq("sb3_unexpected_valid", 1, 0);
         else begin
            m3 = sb3.pop_front();
            check_eq("vec3", vec3, m3.vec);
            check_eq("s3", s3, m3.s);
            check_eq("mism3", mism3, m3.mism);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && valid8) begin
         if (sb8.size() == 0) check_eq("sb8_unexpected_valid", 1, 0);
         else begin
            m8 = sb8.pop_front();
            check_eq("vec8", vec8, m8.vec);
            check_eq("s8", s8, m8.s);
            check_eq("mism8", mism8, m8.mism);
         end
      end
   end

   // One N=3 sweep. hold_at/retrig_at < 0 disables that disturbance.
   task automatic sweep3(input logic [7:0] t, input logic [7:0] e,
                         input int hold_at, input int hold_len,
                         input int retrig_at);
      int   ones = 0, errs = 0, fb = 0, cyc = 0, nval = 0, hcnt = 0;
      bit   any = 0, held = 0, retrig = 0;
      exp_t x;
      for (int v = 0; v < 8; v++) begin
         x.vec  = v;
         x.s    = t[v];
         x.mism = t[v] ^ e[v];
         sb3.push_back(x);
         ones += int'(t[v]);
         if (x.mism) begin
            errs++;
            if (!any) fb = v;
            any = 1;
         end
      end
      tt3 = t; exp3 = e; start3 = 1'b1;
      @(posedge clk) #1;
      start3 = 1'b0;
      tt3 = ~t; exp3 = ~e;   // must not affect the latched sweep
      check_eq("busy_after_start", busy3, 1);
      check_eq("valid_after_start", valid3, 0);
      while (cyc < 40) begin
         @(posedge clk) #1;
         cyc++;
         if (hold3) check_eq("valid_during_hold", valid3, 0);
         if (start3) start3 = 1'b0;
         if (hcnt > 0) begin
            hcnt--;
            if (hcnt == 0) hold3 = 1'b0;
         end
         if (valid3) nval++;
         if (valid3 && int'(vec3) == hold_at && !held) begin
            held = 1; hold3 = 1'b1; hcnt = hold_len;
         end
         if (valid3 && int'(vec3) == retrig_at && !retrig) begin
            retrig = 1; start3 = 1'b1; tt3 = 8'h00;
         end
         if (done3) break;
      end
      check_eq("done_cycle", cyc, 9 + hold_len);
      check_eq("valid_count", nval, 8);
      check_eq("done_valid_low", valid3, 0);
      check_eq("done_busy_low", busy3, 0);
      check_eq("ones_count", ones3, ones);
      check_eq("err_count", err3, errs);
      check_eq("first_bad", first_bad3, fb);
      check_eq("any_bad", any_bad3, any);
      check_eq("sb3_drained", sb3.size(), 0);
      @(posedge clk) #1;
      check_eq("done_one_cycle", done3, 0);
      check_eq("ones_hold", ones3, ones);
      check_eq("err_hold", err3, errs);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cyc, nval;
      exp_t x;

      rst = 1'b1;
      start3 = 1'b0; hold3 = 1'b0; tt3 = '0; exp3 = '0;
      start8 = 1'b0; hold8 = 1'b0; tt8 = '0; exp8 = '0;
      #1;
      check_eq("rst_busy", busy3, 0);
      check_eq("rst_valid", valid3, 0);
      check_eq("rst_vec", vec3, 0);
      check_eq("rst_s", s3, 0);
      check_eq("rst_mism", mism3, 0);
      check_eq("rst_done", done3, 0);
      check_eq("rst_ones", ones3, 0);
      check_eq("rst_err", err3, 0);
      check_eq("rst_first_bad", first_bad3, 0);
      check_eq("rst_any_bad", any_bad3, 0);
      @(posedge clk) #1;
      rst = 1'b0;
      @(posedge clk) #1;
      check_eq("idle_no_busy", busy3, 0);

      sweep3(TT_G01D, TT_G01D, -1, 0, -1);
      sweep3(TT_G01D, 8'h8E, -1, 0, -1);
      sweep3(TT_ONE, TT_ONE, -1, 0, -1);
      sweep3(TT_ZERO, TT_ZERO, -1, 0, -1);
      sweep3(TT_G01D, TT_G01D, 4, 3, -1);
      sweep3(TT_G01D, 8'h8E, -1, 0, 3);

      // Reset in the middle of a sweep.
      for (int v = 0; v < 8; v++) begin
         x.vec = v; x.s = TT_G01D[v]; x.mism = 1'b0;
         sb3.push_back(x);
      end
      tt3 = TT_G01D; exp3 = TT_G01D; start3 = 1'b1;
      @(posedge clk) #1;
      start3 = 1'b0;
      cyc = 0;
      while (cyc < 20) begin
         @(posedge clk) #1;
         cyc++;
         if (valid3 && vec3 == 3'd5) break;
      end
      check_eq("abort_reached_vec5", vec3, 5);
      rst = 1'b1;
      #1;
      check_eq("abort_busy", busy3, 0);
      check_eq("abort_valid", valid3, 0);
      check_eq("abort_vec", vec3, 0);
      check_eq("abort_ones", ones3, 0);
      check_eq("abort_err", err3, 0);
      check_eq("abort_done", done3, 0);
      sb3.delete();
      @(posedge clk) #1;
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk) #1;
         check_eq("abort_no_done", done3, 0);
      end
      sweep3(TT_G01D, 8'h8E, -1, 0, -1);

      // N=8: bits 0 and 255 set; expected table differs at vector 128.
      tt8 = '0; tt8[0] = 1'b1; tt8[255] = 1'b1;
      exp8 = tt8; exp8[128] = 1'b1;
      for (int v = 0; v < 256; v++) begin
         x.vec = v; x.s = tt8[v]; x.mism = tt8[v] ^ exp8[v];
         sb8.push_back(x);
      end
      start8 = 1'b1;
      @(posedge clk) #1;
      start8 = 1'b0;
      cyc = 0; nval = 0;
      while (cyc < 400) begin
         @(posedge clk) #1;
         cyc++;
         if (valid8) nval++;
         if (done8) break;
      end
      check_eq("n8_done_cycle", cyc, 257);
      check_eq("n8_valid_count", nval, 256);
      check_eq("n8_ones", ones8, 2);
      check_eq("n8_err", err8, 1);
      check_eq("n8_first_bad", first_bad8, 128);
      check_eq("n8_any_bad", any_bad8, 1);
      check_eq("n8_last_vec", vec8, 255);
      check_eq("sb8_drained", sb8.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
